// File: rtl/serial_to_parallel.sv
// Serial-in / parallel-out receiver.
// Collects qualified serial bits into a word, then parks the finished word in a
// one-entry holding register drained through a valid/ready handshake. A word
// that finishes while the holding register is still occupied is dropped, and
// the sticky overrun flag records that it was lost.
module serial_to_parallel #(
    parameter int width     = 8,
    parameter bit msb_first = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      serial_in,
    input  logic                      serial_valid,
    input  logic                      frame_start,
    output logic [0:width-1]          data_out,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic [$clog2(width)-1:0]  bit_count,
    output logic                      overrun
);

    localparam int              CW   = $clog2(width);
    localparam logic [CW-1:0]   LAST = CW'(width - 1);

    logic [0:width-1] shift_q, shift_d, shift_base;
    logic [CW-1:0]    count_q, count_d;
    logic [0:width-1] hold_q, hold_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             word_done;

    // Shift path: a qualified bit enters the word; frame_start restarts the word at this bit
    always_comb begin
        shift_base = frame_start ? '0 : shift_q;
        shift_d    = shift_q;
        count_d    = count_q;
        word_done  = 1'b0;
        if (serial_valid) begin
            if (msb_first) begin
                shift_d = {shift_base[1:width-1], serial_in};
            end else begin
                shift_d = {serial_in, shift_base[0:width-2]};
            end
            if (frame_start) begin
                count_d = CW'(1);
            end else if (count_q == LAST) begin
                count_d   = '0;
                word_done = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Holding register: drain on transfer, load a finished word when there is room, else flag overrun
    always_comb begin
        hold_d    = hold_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
        if (word_done) begin
            if (!valid_q || data_ready) begin
                hold_d  = shift_d;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset; a partial word is simply thrown away
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q   <= '0;
            count_q   <= '0;
            hold_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            count_q   <= count_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_out   = hold_q;
    assign data_valid = valid_q;
    assign bit_count  = count_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Scoreboard bench for serial_to_parallel.
// Three instances share the serial stimulus: an MSB-first and an LSB-first
// 8-bit receiver, plus a 2-bit receiver enabled only for its own phase.
// Expected words are queued when sent; a negedge monitor pops and compares
// them whenever a transfer is about to occur.
`timescale 1ns/1ps
module tb_serial_to_parallel;

    logic       clock = 1'b0;
    logic       reset;
    logic       serial_in;
    logic       serial_valid;
    logic       frame_start;
    logic       data_ready;
    logic       w2_en;
    logic       ready_w2;
    logic       sv_w2;

    logic [0:7] dout_m, dout_l;
    logic       valid_m, valid_l, ovr_m, ovr_l;
    logic [2:0] bc_m, bc_l;
    logic [0:1] dout_w2;
    logic       valid_w2, ovr_w2;
    logic [0:0] bc_w2;

    int total = 0;
    int bad   = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    assign sv_w2 = serial_valid & w2_en;

    always #5 clock = ~clock;

    serial_to_parallel #(.width(8), .msb_first(1'b1)) u_msb (
        .clock(clock), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
        .frame_start(frame_start), .data_out(dout_m), .data_valid(valid_m),
        .data_ready(data_ready), .bit_count(bc_m), .overrun(ovr_m));

    serial_to_parallel #(.width(8), .msb_first(1'b0)) u_lsb (
        .clock(clock), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
        .frame_start(frame_start), .data_out(dout_l), .data_valid(valid_l),
        .data_ready(data_ready), .bit_count(bc_l), .overrun(ovr_l));

    serial_to_parallel #(.width(2), .msb_first(1'b1)) u_w2 (
        .clock(clock), .reset(reset), .serial_in(serial_in), .serial_valid(sv_w2),
        .frame_start(frame_start), .data_out(dout_w2), .data_valid(valid_w2),
        .data_ready(ready_w2), .bit_count(bc_w2), .overrun(ovr_w2));

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = v[7-k];
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sendBit(input logic b, input logic fs);
        serial_in    = b;
        serial_valid = 1'b1;
        frame_start  = fs;
        tick();
        serial_valid = 1'b0;
        frame_start  = 1'b0;
    endtask

    // Sends w first-bit = w[7]; optional random gaps, count checks, ready on the last bit
    task automatic applyStimulus(input logic [7:0] w, input int maxGap, input bit checkCnt,
                                 input bit readyLast, input bit keep);
        int n;
        if (keep) begin
            q_m.push_back(w);
            q_l.push_back(rev8(w));
        end
        for (int i = 7; i >= 0; i--) begin
            n = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
            for (int g = 0; g < n; g++) begin
                tick();
                if (checkCnt) checkOutput("gap_count", 32'(bc_m), 32'(7 - i));
            end
            if (readyLast && i == 0) data_ready = 1'b1;
            sendBit(w[i], 1'b0);
            if (checkCnt) checkOutput("bit_count", 32'(bc_m), 32'((8 - i) % 8));
        end
    endtask

    // Monitor: every transfer must match the oldest queued expectation
    always @(negedge clock) begin
        if (valid_m && data_ready) begin
            if (q_m.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL msb_word: unexpected word %0h, none queued", dout_m);
            end else begin
                checkOutput("msb_word", 32'(dout_m), 32'(q_m.pop_front()));
            end
        end
        if (valid_l && data_ready) begin
            if (q_l.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL lsb_word: unexpected word %0h, none queued", dout_l);
            end else begin
                checkOutput("lsb_word", 32'(dout_l), 32'(q_l.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset        = 1'b1;
        serial_in    = 1'b0;
        serial_valid = 1'b0;
        frame_start  = 1'b0;
        data_ready   = 1'b1;
        w2_en        = 1'b0;
        ready_w2     = 1'b0;
        tick();
        tick();
        checkOutput("reset_valid", 32'(valid_m), 32'd0);
        checkOutput("reset_data", 32'(dout_m), 32'd0);
        checkOutput("reset_count", 32'(bc_m), 32'd0);
        checkOutput("reset_overrun", 32'(ovr_m), 32'd0);
        reset = 1'b0;
        tick();

        // Consecutive bits, word visible for exactly one cycle
        applyStimulus(8'hD1, 0, 1'b1, 1'b0, 1'b1);
        checkOutput("t1_valid", 32'(valid_m), 32'd1);
        checkOutput("t1_data", 32'(dout_m), 32'hD1);
        tick();
        checkOutput("t1_one_cycle", 32'(valid_m), 32'd0);

        // Same word with gaps
        applyStimulus(8'hD1, 3, 1'b1, 1'b0, 1'b1);
        checkOutput("t2_valid", 32'(valid_m), 32'd1);
        tick();
        tick();

        // LSB-first ordering
        applyStimulus(8'h80, 0, 1'b0, 1'b0, 1'b1);
        checkOutput("t3_lsb_data", 32'(dout_l), 32'h01);
        tick();

        // Back-pressure drops the second word
        data_ready = 1'b0;
        applyStimulus(8'hA5, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h3C, 0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_held", 32'(dout_m), 32'hA5);
        checkOutput("t4_overrun", 32'(ovr_m), 32'd1);
        checkOutput("t4_overrun_lsb", 32'(ovr_l), 32'd1);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        checkOutput("t4_drained", 32'(valid_m), 32'd0);
        checkOutput("t4_sticky", 32'(ovr_m), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("t4_ovr_cleared", 32'(ovr_m), 32'd0);

        // Completion coincides with a transfer
        applyStimulus(8'h11, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h22, 0, 1'b0, 1'b1, 1'b1);
        data_ready = 1'b0;
        checkOutput("t5_valid", 32'(valid_m), 32'd1);
        checkOutput("t5_data", 32'(dout_m), 32'h22);
        checkOutput("t5_overrun", 32'(ovr_m), 32'd0);
        data_ready = 1'b1;
        tick();
        checkOutput("t5_drained", 32'(valid_m), 32'd0);

        // Resync mid-word
        sendBit(1'b1, 1'b0); sendBit(1'b0, 1'b0); sendBit(1'b1, 1'b0);
        sendBit(1'b1, 1'b0); sendBit(1'b1, 1'b0);
        checkOutput("t6_partial", 32'(bc_m), 32'd5);
        q_m.push_back(8'h5A);
        q_l.push_back(rev8(8'h5A));
        sendBit(1'b0, 1'b1);
        checkOutput("t6_resync_count", 32'(bc_m), 32'd1);
        sendBit(1'b1, 1'b0); sendBit(1'b0, 1'b0); sendBit(1'b1, 1'b0);
        sendBit(1'b1, 1'b0); sendBit(1'b0, 1'b0); sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        checkOutput("t6_word", 32'(dout_m), 32'h5A);
        tick();

        // Reset mid-word
        sendBit(1'b1, 1'b0); sendBit(1'b1, 1'b0); sendBit(1'b1, 1'b0);
        sendBit(1'b1, 1'b0); sendBit(1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("t6r_valid", 32'(valid_m), 32'd0);
        checkOutput("t6r_data", 32'(dout_m), 32'd0);
        checkOutput("t6r_count", 32'(bc_m), 32'd0);
        checkOutput("t6r_overrun", 32'(ovr_m), 32'd0);
        applyStimulus(8'hC3, 0, 1'b1, 1'b0, 1'b1);
        checkOutput("t6r_word", 32'(dout_m), 32'hC3);
        tick();

        // Width-2 receiver
        w2_en = 1'b1;
        sendBit(1'b1, 1'b0);
        checkOutput("w2_count", 32'(bc_w2), 32'd1);
        sendBit(1'b0, 1'b0);
        checkOutput("w2_valid", 32'(valid_w2), 32'd1);
        checkOutput("w2_data", 32'(dout_w2), 32'h2);
        checkOutput("w2_wrap", 32'(bc_w2), 32'd0);
        sendBit(1'b1, 1'b0);
        ready_w2 = 1'b1;
        sendBit(1'b1, 1'b0);
        ready_w2 = 1'b0;
        checkOutput("w2_reload", 32'(dout_w2), 32'h3);
        checkOutput("w2_overrun", 32'(ovr_w2), 32'd0);
        w2_en = 1'b0;
        tick();
        tick();

        checkOutput("queue_msb_empty", 32'(q_m.size()), 32'd0);
        checkOutput("queue_lsb_empty", 32'(q_l.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
